kernel_collector: RTL and testbench
===================================

KERNEL_COLLECTOR -- requirements
Module: kernel_collector

Interface
REQ-001 SHALL have parameter NumberOfK, default 4, meaning the number of kernel lanes that return results.
REQ-002 SHALL have parameter CyclesPerPixel, default 2, meaning the number of cycles the upstream dispatcher spreads one pixel over; it is informative only and SHALL NOT change the function.
REQ-003 SHALL have parameter BitSize, default 2, meaning the width of one kernel result.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 SHALL have port res_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port lane_valid, input, NumberOfK bits: bit i high means lane i presents a result this cycle.
REQ-007 SHALL have port lane_data, input, NumberOfK*BitSize bits: lane i's result occupies bits [i*BitSize +: BitSize].
REQ-008 SHALL have port lane_ready, output, NumberOfK bits: bit i high means lane i's result is accepted this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: an assembled pixel vector is available.
REQ-010 SHALL have port out_data, output, NumberOfK*BitSize bits: the assembled vector, with lane i at [i*BitSize +: BitSize].
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-012 SHALL have port overflow_err, output, 1 bit: sticky flag meaning a lane result was dropped.
REQ-013 SHALL have port frame_cnt, output, 16 bits: the number of delivered vectors, wrapping modulo 2^16.

Function
REQ-014 SHALL hold one assembly slot per lane, each with a filled flag and a BitSize data register.
REQ-015 SHALL drive lane_ready[i] as the OR of not-filled[i] and xfer; this gives a combinational path from out_ready to lane_ready, which is intended.
REQ-016 SHALL define xfer, per cycle, as all filled flags set AND (out_valid low OR out_ready high).
REQ-017 SHALL, on xfer at a rising edge, copy all slot data to the output register, set out_valid, and clear every filled flag.
REQ-018 SHALL, when lane_valid[i] and lane_ready[i] are both high at an edge, capture lane data i and set filled[i]; a capture in the same edge as xfer SHALL be written into the new frame and SHALL leave filled[i] set.
REQ-019 SHALL, on an out_valid and out_ready handshake without xfer, clear out_valid; with xfer in the same edge, out_valid SHALL remain high and out_data SHALL take the new vector.
REQ-020 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-021 SHALL deliver with a latency of 2 edges: when the last missing lane is captured at edge E and the output is free, out_valid SHALL be high after edge E+1.
REQ-022 SHALL accept lanes in any order, at any rate, and in any grouping, including all lanes in one cycle or one lane per cycle.
REQ-023 SHALL, when lane_valid[i] is high and lane_ready[i] is low, discard the data, leave the slot unchanged, and set overflow_err; overflow_err SHALL clear only on reset.
REQ-024 SHALL increment frame_cnt on each out_valid and out_ready handshake, wrapping from 65535 to 0.
REQ-025 SHALL provide a throughput of one vector per cycle when every lane is valid every cycle and out_ready is held high.

Reset
REQ-026 SHALL, while res_n is low, immediately clear all filled flags, out_valid, out_data, overflow_err and frame_cnt to 0, with lane_ready then reading all ones.
REQ-027 SHALL discard any partial frame or undelivered vector when reset is asserted mid-operation, with no output afterward.
REQ-028 SHALL resume after reset deassertion so that the first edge with res_n high may capture lane data.

Verification
REQ-029 SHALL cover ordered groups: lanes {0,1} with data {1,2}, then the next cycle lanes {2,3} with data {3,0}, out_ready high -> out_valid one cycle, out_data = 8'b00_11_10_01, frame_cnt = 1.
REQ-030 SHALL cover out-of-order arrival: lane 3, then lane 0, then lanes {1,2} over three cycles -> exactly one vector, correct placement, 2-edge latency after the last lane.
REQ-031 SHALL cover backpressure: out_ready low, two full frames sent -> the second frame waits in the slots, lane_ready = 0; raising out_ready delivers frame 1 and then frame 2 in consecutive cycles, and overflow_err stays 0.
REQ-032 SHALL cover overflow: lane 2 valid twice (data 1 then 3) before the frame completes -> overflow_err = 1 and sticky, with lane 2 output = 1.
REQ-033 SHALL cover streaming: all lanes valid for 10 cycles, out_ready high -> 10 vectors in consecutive cycles, frame_cnt = 10.
REQ-034 SHALL cover reset mid-frame: lanes {0,1} filled, res_n pulsed low asynchronously between edges -> outputs cleared immediately, and a subsequent full frame delivers only the new data.

Source files
------------

// File: rtl/kernel_collector.sv
// Gathers one result per kernel lane into a pixel vector and emits it once every lane has reported.
// Latency: 2 edges from the last lane capture to out_valid. Backpressure: full slots drop lane_ready until the output frees up.
module kernel_collector #(
    parameter int NumberOfK      = 4,
    parameter int CyclesPerPixel = 2,
    parameter int BitSize        = 2
) (
    input  logic                         clk,
    input  logic                         res_n,
    input  logic [NumberOfK-1:0]         lane_valid,
    input  logic [NumberOfK*BitSize-1:0] lane_data,
    output logic [NumberOfK-1:0]         lane_ready,
    output logic                         out_valid,
    output logic [NumberOfK*BitSize-1:0] out_data,
    input  logic                         out_ready,
    output logic                         overflow_err,
    output logic [15:0]                  frame_cnt
);

    localparam int W = NumberOfK * BitSize;

    // CyclesPerPixel only describes the dispatcher's pacing; the collector is rate-agnostic.
    if (CyclesPerPixel < 1) begin : g_cpp_check
        $error("CyclesPerPixel must be at least 1");
    end

    logic [NumberOfK-1:0] filled_q, filled_d;
    logic [W-1:0]         slot_q, slot_d;
    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         out_data_q, out_data_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 xfer;
    logic [NumberOfK-1:0] accept;

    always_comb begin
        xfer       = (&filled_q) && (!out_valid_q || out_ready);
        // A lane may refill its slot in the same edge the completed frame moves out.
        lane_ready = ~filled_q | {NumberOfK{xfer}};
        accept     = lane_valid & lane_ready;

        filled_d = xfer ? accept : (filled_q | accept);
        slot_d   = slot_q;
        for (int i = 0; i < NumberOfK; i++) begin
            if (accept[i]) begin
                slot_d[i*BitSize +: BitSize] = lane_data[i*BitSize +: BitSize];
            end
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = slot_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        ovf_d = ovf_q | (|(lane_valid & ~lane_ready));
        cnt_d = cnt_q;
        if (out_valid_q && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            filled_q    <= '0;
            slot_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            filled_q    <= filled_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign overflow_err = ovf_q;
    assign frame_cnt    = cnt_q;

endmodule

// File: tb/tb_kernel_collector.sv
// Directed bench for kernel_collector: expected vectors are queued by the stimulus and checked by a monitor on every output handshake.
module tb_kernel_collector;

    localparam int N = 4;
    localparam int B = 2;
    localparam int W = N * B;

    logic         clk;
    logic         res_n;
    logic [N-1:0] lane_valid;
    logic [W-1:0] lane_data;
    logic [N-1:0] lane_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         overflow_err;
    logic [15:0]  frame_cnt;

    int tests;
    int fails;
    logic [W-1:0] exp_q[$];

    kernel_collector #(
        .NumberOfK(N),
        .CyclesPerPixel(2),
        .BitSize(B)
    ) dut (
        .clk(clk),
        .res_n(res_n),
        .lane_valid(lane_valid),
        .lane_data(lane_data),
        .lane_ready(lane_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .overflow_err(overflow_err),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest queued vector.
    always @(negedge clk) begin
        if (res_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_vector", {24'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                check("vector", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [W-1:0] d);
        lane_valid = v;
        lane_data  = d;
        @(posedge clk);
        #1;
        lane_valid = '0;
        lane_data  = '0;
    endtask

    logic [W-1:0] stream_tbl [10];

    initial begin
        tests      = 0;
        fails      = 0;
        res_n      = 1'b0;
        lane_valid = '0;
        lane_data  = '0;
        out_ready  = 1'b1;
        stream_tbl = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

        #2;
        check("rst_lane_ready", {28'd0, lane_ready}, 32'hF);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_overflow", {31'd0, overflow_err}, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        cycle();
        res_n = 1'b1;

        // Ordered groups: lanes {0,1} then {2,3}.
        exp_q.push_back(8'h39);
        drive(4'h3, 8'h09);
        drive(4'hC, 8'h30);
        check("grp_lat_early", {31'd0, out_valid}, 32'd0);
        cycle();
        check("grp_valid", {31'd0, out_valid}, 32'd1);
        check("grp_data", {24'd0, out_data}, 32'h39);
        cycle();
        check("grp_one_cycle", {31'd0, out_valid}, 32'd0);
        check("grp_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // Out-of-order: lane 3, lane 0, then lanes {1,2}.
        exp_q.push_back(8'hA7);
        drive(4'h8, 8'h80);
        drive(4'h1, 8'h03);
        check("ooo_partial", {31'd0, out_valid}, 32'd0);
        drive(4'h6, 8'h24);
        check("ooo_lat_early", {31'd0, out_valid}, 32'd0);
        cycle();
        check("ooo_valid", {31'd0, out_valid}, 32'd1);
        check("ooo_data", {24'd0, out_data}, 32'hA7);
        cycle();
        check("ooo_one_vector", {31'd0, out_valid}, 32'd0);
        check("ooo_frame_cnt", {16'd0, frame_cnt}, 32'd2);

        // Backpressure: two frames queue behind a stalled output.
        out_ready = 1'b0;
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'hE4);
        drive(4'hF, 8'h1B);
        drive(4'hF, 8'hE4);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_lane_ready", {28'd0, lane_ready}, 32'd0);
        cycle();
        cycle();
        check("bp_hold_data", {24'd0, out_data}, 32'h1B);
        out_ready = 1'b1;
        cycle();
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_second_data", {24'd0, out_data}, 32'hE4);
        cycle();
        check("bp_drain", {31'd0, out_valid}, 32'd0);
        check("bp_overflow", {31'd0, overflow_err}, 32'd0);
        check("bp_frame_cnt", {16'd0, frame_cnt}, 32'd4);

        // Overflow: lane 2 reports twice before the frame completes.
        exp_q.push_back(8'h5E);
        drive(4'h4, 8'h10);
        check("ovf_clear_before", {31'd0, overflow_err}, 32'd0);
        drive(4'h4, 8'h30);
        check("ovf_set", {31'd0, overflow_err}, 32'd1);
        drive(4'hB, 8'h4E);
        cycle();
        check("ovf_data", {24'd0, out_data}, 32'h5E);
        cycle();
        check("ovf_sticky", {31'd0, overflow_err}, 32'd1);
        check("ovf_frame_cnt", {16'd0, frame_cnt}, 32'd5);

        // Streaming: all lanes every cycle for 10 cycles.
        for (int i = 0; i < 10; i++) exp_q.push_back(stream_tbl[i]);
        lane_valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            lane_data = stream_tbl[i];
            @(posedge clk);
            #1;
            if (i >= 1) check("stream_valid", {31'd0, out_valid}, 32'd1);
        end
        lane_valid = '0;
        lane_data  = '0;
        cycle();
        check("stream_last_valid", {31'd0, out_valid}, 32'd1);
        check("stream_last_data", {24'd0, out_data}, 32'hBC);
        cycle();
        check("stream_end", {31'd0, out_valid}, 32'd0);
        check("stream_frame_cnt", {16'd0, frame_cnt}, 32'd15);

        // Reset mid-frame with lanes {0,1} already filled.
        drive(4'h3, 8'h0F);
        @(negedge clk);
        #2;
        res_n = 1'b0;
        #1;
        check("mrst_lane_ready", {28'd0, lane_ready}, 32'hF);
        check("mrst_out_data", {24'd0, out_data}, 32'd0);
        check("mrst_overflow", {31'd0, overflow_err}, 32'd0);
        check("mrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        #1;
        res_n = 1'b1;
        cycle();
        exp_q.push_back(8'h64);
        drive(4'hC, 8'h60);
        cycle();
        check("mrst_no_stale", {31'd0, out_valid}, 32'd0);
        drive(4'h3, 8'h04);
        cycle();
        check("mrst_valid", {31'd0, out_valid}, 32'd1);
        check("mrst_data", {24'd0, out_data}, 32'h64);
        cycle();
        check("mrst_frame_cnt_after", {16'd0, frame_cnt}, 32'd1);

        cycle();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
